// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply and
// radix-2 restoring divide, WIDTH iterations each, plus MTHI/MTLO writes while idle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic             busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_mul_q, is_mul_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  // a: multiplier / dividend->quotient, p: partial product high / remainder, b: mcand / divisor
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   a_step, p_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // One iteration of whichever operation is in flight.
  always_comb begin
    mul_sum   = {1'b0, p_q} + (a_q[0] ? {1'b0, b_q} : '0);
    div_shift = {p_q, a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_mul_q) begin
      p_step = mul_sum[WIDTH:1];
      a_step = {mul_sum[0], a_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      p_step = div_diff[WIDTH-1:0];
      a_step = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      p_step = div_shift[WIDTH-1:0];
      a_step = {a_q[WIDTH-2:0], 1'b0};
    end
    prod     = {p_step, a_step};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -a_step : a_step;
    rem_fix  = neg_rem_q ? -p_step : p_step;
  end

  always_comb begin
    sign_a = SrcA[WIDTH-1];
    sign_b = SrcB[WIDTH-1];
    mag_a  = sign_a ? -SrcA : SrcA;
    mag_b  = sign_b ? -SrcB : SrcB;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mul_d  = is_mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    p_d       = p_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (validIn) begin
          case (op)
            OpMult, OpDiv: begin
              a_d       = mag_a;
              b_d       = mag_b;
              p_d       = '0;
              cnt_d     = '0;
              is_mul_d  = (op == OpMult);
              neg_res_d = sign_a ^ sign_b;
              neg_rem_d = sign_a;
              state_d   = StRun;
            end
            OpMultu, OpDivu: begin
              a_d       = SrcA;
              b_d       = SrcB;
              p_d       = '0;
              cnt_d     = '0;
              is_mul_d  = (op == OpMultu);
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = StRun;
            end
            OpMthi:  hi_d = SrcA;
            OpMtlo:  lo_d = SrcB;
            default: ;
          endcase
        end
      end
      StRun: begin
        a_d   = a_step;
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else begin
            // Divide by zero: remainder path already reproduces the raw dividend.
            hi_d = rem_fix;
            lo_d = (b_q == '0) ? '1 : quo_fix;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      p_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mul_q  <= is_mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      p_q       <= p_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign validOut = (state_q == StDone);
  assign busy     = (state_q == StRun);
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results, MTHI/MTLO, ignored requests, reset.
module tb_mul_div_unit;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  logic        clk;
  logic        reset;
  logic        validIn;
  logic [2:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        validOut, busy;
  logic [31:0] Hi, Lo;

  int n_cmp;
  int n_err;
  int vo_cnt;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .op       (op),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .validOut (validOut),
    .busy     (busy),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (validOut) vo_cnt <= vo_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request in the current cycle and waits (bounded) for validOut.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject);
    int lat;
    validIn = 1'b1;
    op      = o;
    SrcA    = a;
    SrcB    = b;
    tick();
    validIn = 1'b0;
    check({tag, ".busy_start"}, 64'(busy), 64'd1);
    lat = 1;
    while (!validOut && lat < 40) begin
      if (inject && lat == 5) begin
        validIn = 1'b1;
        op      = OpDivu;
        SrcA    = 32'd99;
        SrcB    = 32'd9;
      end else if (inject && lat == 6) begin
        op   = OpMthi;
        SrcA = 32'hDEAD;
      end else begin
        validIn = 1'b0;
      end
      tick();
      lat++;
    end
    validIn = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'd33);
    check({tag, ".busy_done"}, 64'(busy), 64'd0);
    check({tag, ".hi"}, 64'(Hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(Lo), 64'(exp_lo));
    tick();
    check({tag, ".pulse_width"}, 64'(validOut), 64'd0);
  endtask

  initial begin
    int vo_before;
    n_cmp   = 0;
    n_err   = 0;
    vo_cnt  = 0;
    reset   = 1'b1;
    validIn = 1'b0;
    op      = OpNop;
    SrcA    = '0;
    SrcB    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst.hi", 64'(Hi), 64'd0);
    check("rst.lo", 64'(Lo), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.vout", 64'(validOut), 64'd0);
    tick();

    run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_m3x7", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("mult_min2", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_op("mult_6xm1", OpMult, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    run_op("div_m7d2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7dm2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    run_op("divu_100d7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div_mindm1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_op("divu_5d0", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("div_m5d0", OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

    // MTHI/MTLO back to back, then unused ops must not start anything.
    vo_before = vo_cnt;
    validIn = 1'b1;
    op      = OpMthi;
    SrcA    = 32'h1234;
    SrcB    = 32'hAAAA;
    tick();
    check("mthi.hi", 64'(Hi), 64'h1234);
    check("mthi.busy", 64'(busy), 64'd0);
    op   = OpMtlo;
    SrcA = 32'hBBBB;
    SrcB = 32'h5678;
    tick();
    op = OpNop;
    tick();
    op = 3'b111;
    tick();
    validIn = 1'b0;
    check("mtlo.hi", 64'(Hi), 64'h1234);
    check("mtlo.lo", 64'(Lo), 64'h5678);
    check("nop.busy", 64'(busy), 64'd0);
    tick();
    check("mtx.no_vout", 64'(vo_cnt - vo_before), 64'd0);

    // Requests during RUN are dropped: one pulse, first op's result.
    vo_before = vo_cnt;
    run_op("ignore_run", OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, 1);
    for (int i = 0; i < 40; i++) tick();
    check("ignore_run.pulses", 64'(vo_cnt - vo_before), 64'd1);
    check("ignore_run.busy", 64'(busy), 64'd0);

    // Reset mid-operation at N+10.
    run_op("pre_rst", OpMultu, 32'd5, 32'd5, 32'd0, 32'd25, 0);
    validIn = 1'b1;
    op      = OpMultu;
    SrcA    = 32'd7;
    SrcB    = 32'd9;
    tick();
    validIn = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vo_before = vo_cnt;
    check("midrst.hi", 64'(Hi), 64'd0);
    check("midrst.lo", 64'(Lo), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) tick();
    check("midrst.no_vout", 64'(vo_cnt - vo_before), 64'd0);
    check("midrst.lo_hold", 64'(Lo), 64'd0);
    run_op("post_rst", OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
